// File: rtl/design_variables.sv
// ---------------------------------------------------------------------------
// design_variables
// Shared types and constants for the traceback datapath.
//   tb_dir_t  : direction code stored per matrix cell (STOP/DIAG/UP/LEFT)
//   tb_op_t   : alignment operation emitted per traceback step
//   TB_STATE  : traceback FSM states
//   MAX_STEPS : hard bound on the number of traceback steps
// ---------------------------------------------------------------------------
package design_variables;

    localparam int MAX_STEPS  = 63;
    localparam int STEP_CNT_W = 6;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_DIAG = 2'b01,
        DIR_UP   = 2'b10,
        DIR_LEFT = 2'b11
    } tb_dir_t;

    typedef enum logic [1:0] {
        TB_OP_MATCH = 2'd0,
        TB_OP_DEL   = 2'd1,
        TB_OP_INS   = 2'd2
    } tb_op_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        STEP,
        DONE
    } TB_STATE;

endpackage

// File: rtl/tb_coord_step.sv
// ---------------------------------------------------------------------------
// tb_coord_step
// Combinational single-step decoder for the traceback walk. Given the current
// cell coordinate and its direction code it produces the predecessor cell,
// the alignment op for this step, whether an op is emitted at all, and
// whether the walk ends after this step.
// Ports:
//   row, col        in   current cell coordinate
//   dir             in   direction code of the current cell
//   step_row/col    out  coordinate of the next cell to visit
//   step_op         out  alignment op for this step
//   emit            out  an op is produced by this step
//   terminate       out  walk ends after this step
// ---------------------------------------------------------------------------
module tb_coord_step
    import design_variables::*;
#(
    parameter int ROW_BITS_WIDTH = 5,
    parameter int COL_BITS_WIDTH = 5
) (
    input  logic [ROW_BITS_WIDTH-1:0] row,
    input  logic [COL_BITS_WIDTH-1:0] col,
    input  logic [1:0]                dir,
    output logic [ROW_BITS_WIDTH-1:0] step_row,
    output logic [COL_BITS_WIDTH-1:0] step_col,
    output logic [1:0]                step_op,
    output logic                      emit,
    output logic                      terminate
);

    // Moves toward index 0 are only taken when the relevant index is
    // non-zero, so the decrements below can never wrap.
    always_comb begin
        step_row  = row;
        step_col  = col;
        step_op   = TB_OP_MATCH;
        emit      = 1'b0;
        terminate = 1'b1;
        case (dir)
            DIR_DIAG: begin
                step_op = TB_OP_MATCH;
                emit    = 1'b1;
                if (row != '0 && col != '0) begin
                    terminate = 1'b0;
                    step_row  = row - 1'b1;
                    step_col  = col - 1'b1;
                end
            end
            DIR_UP: begin
                step_op = TB_OP_DEL;
                emit    = 1'b1;
                if (row != '0) begin
                    terminate = 1'b0;
                    step_row  = row - 1'b1;
                end
            end
            DIR_LEFT: begin
                step_op = TB_OP_INS;
                emit    = 1'b1;
                if (col != '0) begin
                    terminate = 1'b0;
                    step_col  = col - 1'b1;
                end
            end
            default: begin
                emit      = 1'b0;
                terminate = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/traceback_unit.sv
// ---------------------------------------------------------------------------
// traceback_unit
// Walks the scored matrix backward from the maximum-score cell, one cell every
// two cycles (READ then STEP), emitting one alignment op per step, and pulses
// finished when the walk ends.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   en_traceback        traceback window; dropping it mid-walk aborts
//   start_of_traceback  one-cycle start pulse
//   max_row/max_col     coordinate of the maximum cell
//   max_score           maximum score; zero means nothing to trace
//   mem_dir             direction of the cell addressed last cycle
//   next_row/next_col   current traceback address
//   op_valid, op        registered op strobe and op code
//   finished            one-cycle completion pulse
//   path_len            ops emitted since start (TB_PATH_LEN_EN only)
// Configuration macro: TB_PATH_LEN_EN
// ---------------------------------------------------------------------------
module traceback_unit
    import design_variables::*;
#(
    parameter int ROW_BITS_WIDTH = 5,
    parameter int COL_BITS_WIDTH = 5,
    parameter int SCORE_W        = 8,
    parameter int MAX_STEPS      = design_variables::MAX_STEPS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_traceback,
    input  logic                      start_of_traceback,
    input  logic [ROW_BITS_WIDTH-1:0] max_row,
    input  logic [COL_BITS_WIDTH-1:0] max_col,
    input  logic [SCORE_W-1:0]        max_score,
    input  logic [1:0]                mem_dir,
    output logic [ROW_BITS_WIDTH-1:0] next_row,
    output logic [COL_BITS_WIDTH-1:0] next_col,
    output logic                      op_valid,
    output logic [1:0]                op,
    output logic                      finished
`ifdef TB_PATH_LEN_EN
    ,
    output logic [5:0]                path_len
`endif
);

    TB_STATE state, state_next;

    logic [ROW_BITS_WIDTH-1:0] row_d;
    logic [COL_BITS_WIDTH-1:0] col_d;
    logic [1:0]                op_d;
    logic                      op_valid_d;
    logic                      finished_d;
    logic [STEP_CNT_W-1:0]     step_cnt, step_cnt_d, step_cnt_inc;

    logic [ROW_BITS_WIDTH-1:0] cs_row;
    logic [COL_BITS_WIDTH-1:0] cs_col;
    logic [1:0]                cs_op;
    logic                      cs_emit;
    logic                      cs_term;

    tb_coord_step #(
        .ROW_BITS_WIDTH (ROW_BITS_WIDTH),
        .COL_BITS_WIDTH (COL_BITS_WIDTH)
    ) u_coord_step (
        .row       (next_row),
        .col       (next_col),
        .dir       (mem_dir),
        .step_row  (cs_row),
        .step_col  (cs_col),
        .step_op   (cs_op),
        .emit      (cs_emit),
        .terminate (cs_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            next_row <= '0;
            next_col <= '0;
            op       <= '0;
            op_valid <= 1'b0;
            finished <= 1'b0;
            step_cnt <= '0;
        end else begin
            state    <= state_next;
            next_row <= row_d;
            next_col <= col_d;
            op       <= op_d;
            op_valid <= op_valid_d;
            finished <= finished_d;
            step_cnt <= step_cnt_d;
        end
    end

    // Losing en_traceback in READ or STEP drops straight back to IDLE
    // without an op or a finished pulse. The step counter saturates so the
    // MAX_STEPS bound can always be detected.
    always_comb begin
        state_next   = state;
        row_d        = next_row;
        col_d        = next_col;
        op_d         = op;
        op_valid_d   = 1'b0;
        step_cnt_d   = step_cnt;
        step_cnt_inc = (step_cnt == STEP_CNT_W'(MAX_STEPS)) ? step_cnt
                                                            : step_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (start_of_traceback && en_traceback) begin
                    row_d      = max_row;
                    col_d      = max_col;
                    step_cnt_d = '0;
                    state_next = (max_score == '0) ? DONE : READ;
                end
            end
            READ: begin
                state_next = en_traceback ? STEP : IDLE;
            end
            STEP: begin
                if (!en_traceback) begin
                    state_next = IDLE;
                end else if (!cs_emit) begin
                    state_next = DONE;
                end else begin
                    op_valid_d = 1'b1;
                    op_d       = cs_op;
                    row_d      = cs_row;
                    col_d      = cs_col;
                    step_cnt_d = step_cnt_inc;
                    state_next = (cs_term || step_cnt_inc == STEP_CNT_W'(MAX_STEPS))
                                 ? DONE : READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        finished_d = (state_next == DONE);
    end

`ifdef TB_PATH_LEN_EN
    // Every emitted op bumps the step counter, so it doubles as the length.
    assign path_len = step_cnt;
`endif

endmodule
